// File: rtl/ctrl_pipe_dec_if.sv
// Control-decoder bus: D-stage instruction in, stage stall/flush in, D/E/M/W control out.
// Latency: none (signal bundle only).
// Backpressure: stall/flush inputs come from the hazard unit; no local flow control.
interface ctrl_pipe_dec_if;
  logic [31:0] instrD;
  logic        validD;
  logic        stallD, stallE, stallM, stallW;
  logic        flushE, flushM, flushW;

  logic        branchD, jumpD, jrD, linkD, reservedD;

  logic        regwriteE, alusrcAE, alusrcBE, immZextE, memtoRegE, linkE, muldivStartE, validE;
  logic [1:0]  regdstE;

  logic        regwriteM, memtoRegM, memWriteM, memReadM, memUnsignedM, validM;
  logic [1:0]  memSizeM;
  logic [1:0]  hiloWeM;

  logic        regwriteW, memtoRegW, validW;
  logic [1:0]  hiloToRegW;

  // Driver side (datapath / hazard unit / bench)
  modport master (
    output instrD, validD, stallD, stallE, stallM, stallW, flushE, flushM, flushW,
    input  branchD, jumpD, jrD, linkD, reservedD,
    input  regwriteE, alusrcAE, alusrcBE, immZextE, memtoRegE, linkE, muldivStartE, validE, regdstE,
    input  regwriteM, memtoRegM, memWriteM, memReadM, memUnsignedM, validM, memSizeM, hiloWeM,
    input  regwriteW, memtoRegW, validW, hiloToRegW
  );

  // Decoder side
  modport slave (
    input  instrD, validD, stallD, stallE, stallM, stallW, flushE, flushM, flushW,
    output branchD, jumpD, jrD, linkD, reservedD,
    output regwriteE, alusrcAE, alusrcBE, immZextE, memtoRegE, linkE, muldivStartE, validE, regdstE,
    output regwriteM, memtoRegM, memWriteM, memReadM, memUnsignedM, validM, memSizeM, hiloWeM,
    output regwriteW, memtoRegW, validW, hiloToRegW
  );
endinterface

// File: rtl/ctrl_pipe_dec.sv
// MIPS control decoder: decodes D-stage instruction and carries the control bundle through E/M/W.
// Latency: D outputs combinational; one cycle per stage D->E->M->W.
// Backpressure: per-stage stall holds, flush bubbles; a held upstream stage injects bubbles downstream.
module ctrl_pipe_dec #(
  parameter bit          SUPPORT_MULDIV = 1'b1,
  parameter bit          SUPPORT_LINK   = 1'b1,
  // Layout (msb..lsb): regwrite, alusrc_a, alusrc_b, imm_zext, memtoreg, link, muldiv,
  // regdst[1:0], mem_write, mem_read, mem_unsigned, mem_size[1:0], hilo_we[1:0], hilo_to_reg[1:0]
  parameter logic [17:0] RESET_BUNDLE   = '0
) (
  input logic             clk,
  input logic             rst,
  ctrl_pipe_dec_if.slave  bus
);

  typedef struct packed {
    logic       regwrite;
    logic       alusrc_a;
    logic       alusrc_b;
    logic       imm_zext;
    logic       memtoreg;
    logic       link;
    logic       muldiv;
    logic [1:0] regdst;
    logic       mem_write;
    logic       mem_read;
    logic       mem_unsigned;
    logic [1:0] mem_size;
    logic [1:0] hilo_we;
    logic [1:0] hilo_to_reg;
  } bundle_t;

  // Only the fields still needed downstream travel past E
  typedef struct packed {
    logic       regwrite;
    logic       memtoreg;
    logic       mem_write;
    logic       mem_read;
    logic       mem_unsigned;
    logic [1:0] mem_size;
    logic [1:0] hilo_we;
    logic [1:0] hilo_to_reg;
  } mbundle_t;

  typedef struct packed {
    logic       regwrite;
    logic       memtoreg;
    logic [1:0] hilo_to_reg;
  } wbundle_t;

  localparam bundle_t  RST_E = bundle_t'(RESET_BUNDLE);
  localparam mbundle_t RST_M = {RST_E.regwrite, RST_E.memtoreg, RST_E.mem_write, RST_E.mem_read,
                                RST_E.mem_unsigned, RST_E.mem_size, RST_E.hilo_we, RST_E.hilo_to_reg};
  localparam wbundle_t RST_W = {RST_E.regwrite, RST_E.memtoreg, RST_E.hilo_to_reg};

  logic [5:0] op, funct;
  logic [4:0] rt;
  assign op    = bus.instrD[31:26];
  assign funct = bus.instrD[5:0];
  assign rt    = bus.instrD[20:16];

  // rs/rd/shamt/immediate fields are datapath-only
  logic unused_instr_bits;
  assign unused_instr_bits = ^{bus.instrD[25:21], bus.instrD[15:6]};

  bundle_t  dec;
  logic     branch_d, jump_d, jr_d, link_d, rsv_d;

  bundle_t  e_q;
  mbundle_t m_q;
  wbundle_t w_q;
  logic     vld_e, vld_m, vld_w;
  logic     issued_e;
  logic     muldiv_start;

  mbundle_t e_fwd;
  wbundle_t m_fwd;
  assign e_fwd = {e_q.regwrite, e_q.memtoreg, e_q.mem_write, e_q.mem_read, e_q.mem_unsigned,
                  e_q.mem_size, e_q.hilo_we, e_q.hilo_to_reg};
  assign m_fwd = {m_q.regwrite, m_q.memtoreg, m_q.hilo_to_reg};

  // D-stage decode; unknown encodings and invalid slots collapse to an all-zero bundle
  always_comb begin
    dec      = '0;
    branch_d = 1'b0;
    jump_d   = 1'b0;
    jr_d     = 1'b0;
    link_d   = 1'b0;
    rsv_d    = 1'b0;
    case (op)
      6'h00: begin
        case (funct)
          6'h00, 6'h02, 6'h03: begin
            dec.regwrite = 1'b1; dec.regdst = 2'd1; dec.alusrc_a = 1'b1;
          end
          6'h04, 6'h06, 6'h07, 6'h20, 6'h21, 6'h22, 6'h23,
          6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b: begin
            dec.regwrite = 1'b1; dec.regdst = 2'd1;
          end
          6'h08: jr_d = 1'b1;
          6'h09: begin
            if (SUPPORT_LINK) begin
              jr_d = 1'b1; link_d = 1'b1;
              dec.regwrite = 1'b1; dec.link = 1'b1; dec.regdst = 2'd1;
            end else rsv_d = 1'b1;
          end
          6'h10: begin
            if (SUPPORT_MULDIV) begin
              dec.regwrite = 1'b1; dec.regdst = 2'd1; dec.hilo_to_reg = 2'b10;
            end else rsv_d = 1'b1;
          end
          6'h12: begin
            if (SUPPORT_MULDIV) begin
              dec.regwrite = 1'b1; dec.regdst = 2'd1; dec.hilo_to_reg = 2'b01;
            end else rsv_d = 1'b1;
          end
          6'h11: begin
            if (SUPPORT_MULDIV) dec.hilo_we = 2'b10;
            else rsv_d = 1'b1;
          end
          6'h13: begin
            if (SUPPORT_MULDIV) dec.hilo_we = 2'b01;
            else rsv_d = 1'b1;
          end
          6'h18, 6'h19, 6'h1a, 6'h1b: begin
            if (SUPPORT_MULDIV) begin
              dec.muldiv = 1'b1; dec.hilo_we = 2'b11;
            end else rsv_d = 1'b1;
          end
          default: rsv_d = 1'b1;
        endcase
      end
      6'h01: begin
        case (rt)
          5'h00, 5'h01: branch_d = 1'b1;
          5'h10, 5'h11: begin
            if (SUPPORT_LINK) begin
              branch_d = 1'b1; link_d = 1'b1;
              dec.regwrite = 1'b1; dec.link = 1'b1; dec.regdst = 2'd2;
            end else rsv_d = 1'b1;
          end
          default: rsv_d = 1'b1;
        endcase
      end
      6'h02: jump_d = 1'b1;
      6'h03: begin
        if (SUPPORT_LINK) begin
          jump_d = 1'b1; link_d = 1'b1;
          dec.regwrite = 1'b1; dec.link = 1'b1; dec.regdst = 2'd2;
        end else rsv_d = 1'b1;
      end
      6'h04, 6'h05, 6'h06, 6'h07: branch_d = 1'b1;
      6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0f: begin
        dec.regwrite = 1'b1; dec.alusrc_b = 1'b1;
      end
      6'h0c, 6'h0d, 6'h0e: begin
        dec.regwrite = 1'b1; dec.alusrc_b = 1'b1; dec.imm_zext = 1'b1;
      end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
        dec.regwrite     = 1'b1;
        dec.alusrc_b     = 1'b1;
        dec.memtoreg     = 1'b1;
        dec.mem_read     = 1'b1;
        dec.mem_unsigned = op[2];
        dec.mem_size     = (op == 6'h23) ? 2'd2 : {1'b0, op[0]};
      end
      6'h28, 6'h29, 6'h2b: begin
        dec.alusrc_b  = 1'b1;
        dec.mem_write = 1'b1;
        dec.mem_size  = (op == 6'h2b) ? 2'd2 : {1'b0, op[0]};
      end
      default: rsv_d = 1'b1;
    endcase
    if (!bus.validD || rsv_d) begin
      dec      = '0;
      branch_d = 1'b0;
      jump_d   = 1'b0;
      jr_d     = 1'b0;
      link_d   = 1'b0;
      rsv_d    = rsv_d & bus.validD;
    end
  end

  // E register: reset/flush > hold > bubble while D holds > advance
  always_ff @(posedge clk) begin
    if (rst || bus.flushE) begin
      e_q   <= RST_E;
      vld_e <= 1'b0;
    end else if (bus.stallE) begin
      e_q   <= e_q;
      vld_e <= vld_e;
    end else if (bus.stallD) begin
      e_q   <= '0;
      vld_e <= 1'b0;
    end else begin
      e_q   <= dec;
      vld_e <= bus.validD;
    end
  end

  // Remember that this E occupant already fired its mult/div start while E is held
  always_ff @(posedge clk) begin
    if (rst || bus.flushE)  issued_e <= 1'b0;
    else if (bus.stallE)    issued_e <= issued_e | muldiv_start;
    else                    issued_e <= 1'b0;
  end

  assign muldiv_start = e_q.muldiv & ~issued_e;

  // M register: same priority, upstream is E
  always_ff @(posedge clk) begin
    if (rst || bus.flushM) begin
      m_q   <= RST_M;
      vld_m <= 1'b0;
    end else if (bus.stallM) begin
      m_q   <= m_q;
      vld_m <= vld_m;
    end else if (bus.stallE) begin
      m_q   <= '0;
      vld_m <= 1'b0;
    end else begin
      m_q   <= e_fwd;
      vld_m <= vld_e;
    end
  end

  // W register: same priority, upstream is M
  always_ff @(posedge clk) begin
    if (rst || bus.flushW) begin
      w_q   <= RST_W;
      vld_w <= 1'b0;
    end else if (bus.stallW) begin
      w_q   <= w_q;
      vld_w <= vld_w;
    end else if (bus.stallM) begin
      w_q   <= '0;
      vld_w <= 1'b0;
    end else begin
      w_q   <= m_fwd;
      vld_w <= vld_m;
    end
  end

  assign bus.branchD      = branch_d;
  assign bus.jumpD        = jump_d;
  assign bus.jrD          = jr_d;
  assign bus.linkD        = link_d;
  assign bus.reservedD    = rsv_d;

  assign bus.regwriteE    = e_q.regwrite;
  assign bus.alusrcAE     = e_q.alusrc_a;
  assign bus.alusrcBE     = e_q.alusrc_b;
  assign bus.immZextE     = e_q.imm_zext;
  assign bus.memtoRegE    = e_q.memtoreg;
  assign bus.linkE        = e_q.link;
  assign bus.muldivStartE = muldiv_start;
  assign bus.validE       = vld_e;
  assign bus.regdstE      = e_q.regdst;

  assign bus.regwriteM    = m_q.regwrite;
  assign bus.memtoRegM    = m_q.memtoreg;
  assign bus.memWriteM    = m_q.mem_write;
  assign bus.memReadM     = m_q.mem_read;
  assign bus.memUnsignedM = m_q.mem_unsigned;
  assign bus.validM       = vld_m;
  assign bus.memSizeM     = m_q.mem_size;
  assign bus.hiloWeM      = m_q.hilo_we;

  assign bus.regwriteW    = w_q.regwrite;
  assign bus.memtoRegW    = w_q.memtoreg;
  assign bus.validW       = vld_w;
  assign bus.hiloToRegW   = w_q.hilo_to_reg;

endmodule

// File: tb/tb_ctrl_pipe_dec.sv
// Bench for ctrl_pipe_dec: full-featured and link/muldiv-less instances driven in lockstep.
// Latency: checks D outputs same cycle, E/M/W one cycle per stage.
// Backpressure: random stalls/flushes/resets exercise hold, bubble and one-shot behaviour.
module tb_ctrl_pipe_dec;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        vld, sd, se, sm, sw, fe, fm, fw;

  int n_chk = 0;
  int n_err = 0;

  ctrl_pipe_dec_if ifa ();
  ctrl_pipe_dec_if ifb ();

  ctrl_pipe_dec u_a (.clk(clk), .rst(rst), .bus(ifa));
  ctrl_pipe_dec #(.SUPPORT_MULDIV(1'b0), .SUPPORT_LINK(1'b0)) u_b (.clk(clk), .rst(rst), .bus(ifb));

  assign ifa.instrD = instr;  assign ifb.instrD = instr;
  assign ifa.validD = vld;    assign ifb.validD = vld;
  assign ifa.stallD = sd;     assign ifb.stallD = sd;
  assign ifa.stallE = se;     assign ifb.stallE = se;
  assign ifa.stallM = sm;     assign ifb.stallM = sm;
  assign ifa.stallW = sw;     assign ifb.stallW = sw;
  assign ifa.flushE = fe;     assign ifb.flushE = fe;
  assign ifa.flushM = fm;     assign ifb.flushM = fm;
  assign ifa.flushW = fw;     assign ifb.flushW = fw;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef enum {K_RSV, K_ALUR, K_SHI, K_ALUI, K_LOGI, K_LUI, K_LD, K_ST, K_BR, K_BRL,
                K_J, K_JAL, K_JR, K_JALR, K_MFHI, K_MFLO, K_MTHI, K_MTLO, K_MD} kind_t;

  typedef struct packed {
    logic br, jmp, jr, lnkd, rsv;
    logic regwrite, alusrc_a, alusrc_b, imm_zext, memtoreg, link, muldiv;
    logic [1:0] regdst;
    logic mem_write, mem_read, mem_unsigned;
    logic [1:0] mem_size, hilo_we, hilo_to_reg;
  } exp_t;

  function automatic kind_t classify(logic [31:0] ins, bit lnk, bit md);
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rt;
    op = ins[31:26]; fn = ins[5:0]; rt = ins[20:16];
    if (op == 0) begin
      if (fn inside {0, 2, 3}) return K_SHI;
      if (fn inside {4, 6, 7, [32:39], 42, 43}) return K_ALUR;
      if (fn == 8)  return K_JR;
      if (fn == 9)  return lnk ? K_JALR : K_RSV;
      if (fn == 16) return md ? K_MFHI : K_RSV;
      if (fn == 17) return md ? K_MTHI : K_RSV;
      if (fn == 18) return md ? K_MFLO : K_RSV;
      if (fn == 19) return md ? K_MTLO : K_RSV;
      if (fn inside {[24:27]}) return md ? K_MD : K_RSV;
      return K_RSV;
    end
    if (op == 1) begin
      if (rt inside {0, 1})   return K_BR;
      if (rt inside {16, 17}) return lnk ? K_BRL : K_RSV;
      return K_RSV;
    end
    if (op == 2) return K_J;
    if (op == 3) return lnk ? K_JAL : K_RSV;
    if (op inside {[4:7]})  return K_BR;
    if (op inside {[8:11]}) return K_ALUI;
    if (op inside {[12:14]}) return K_LOGI;
    if (op == 15) return K_LUI;
    if (op inside {32, 33, 35, 36, 37}) return K_LD;
    if (op inside {40, 41, 43}) return K_ST;
    return K_RSV;
  endfunction

  function automatic logic [1:0] msize(logic [5:0] op);
    if (op inside {32, 36, 40}) return 2'd0;
    if (op inside {33, 37, 41}) return 2'd1;
    return 2'd2;
  endfunction

  function automatic exp_t dec_model(logic [31:0] ins, bit v, bit lnk, bit md);
    exp_t x;
    x = '0;
    if (!v) return x;
    case (classify(ins, lnk, md))
      K_RSV:  x.rsv = 1;
      K_ALUR: begin x.regwrite = 1; x.regdst = 1; end
      K_SHI:  begin x.regwrite = 1; x.regdst = 1; x.alusrc_a = 1; end
      K_ALUI, K_LUI: begin x.regwrite = 1; x.alusrc_b = 1; end
      K_LOGI: begin x.regwrite = 1; x.alusrc_b = 1; x.imm_zext = 1; end
      K_LD: begin
        x.regwrite = 1; x.alusrc_b = 1; x.memtoreg = 1; x.mem_read = 1;
        x.mem_size = msize(ins[31:26]); x.mem_unsigned = (ins[31:26] inside {36, 37});
      end
      K_ST:   begin x.alusrc_b = 1; x.mem_write = 1; x.mem_size = msize(ins[31:26]); end
      K_BR:   x.br = 1;
      K_BRL:  begin x.br = 1; x.lnkd = 1; x.regwrite = 1; x.link = 1; x.regdst = 2; end
      K_J:    x.jmp = 1;
      K_JAL:  begin x.jmp = 1; x.lnkd = 1; x.regwrite = 1; x.link = 1; x.regdst = 2; end
      K_JR:   x.jr = 1;
      K_JALR: begin x.jr = 1; x.lnkd = 1; x.regwrite = 1; x.link = 1; x.regdst = 1; end
      K_MFHI: begin x.regwrite = 1; x.regdst = 1; x.hilo_to_reg = 2'b10; end
      K_MFLO: begin x.regwrite = 1; x.regdst = 1; x.hilo_to_reg = 2'b01; end
      K_MTHI: x.hilo_we = 2'b10;
      K_MTLO: x.hilo_we = 2'b01;
      K_MD:   begin x.muldiv = 1; x.hilo_we = 2'b11; end
      default: x.rsv = 1;
    endcase
    return x;
  endfunction

  function automatic logic [4:0] vd(exp_t x);
    return {x.br, x.jmp, x.jr, x.lnkd, x.rsv};
  endfunction
  function automatic logic [9:0] ve(exp_t x, bit v, bit start);
    return {x.regwrite, x.alusrc_a, x.alusrc_b, x.imm_zext, x.memtoreg, x.link, start, v, x.regdst};
  endfunction
  function automatic logic [9:0] vm(exp_t x, bit v);
    return {x.regwrite, x.memtoreg, x.mem_write, x.mem_read, x.mem_unsigned, v, x.mem_size, x.hilo_we};
  endfunction
  function automatic logic [4:0] vw(exp_t x, bit v);
    return {x.regwrite, x.memtoreg, v, x.hilo_to_reg};
  endfunction

  // Pipeline occupancy: which instruction word sits in each stage, and how long E has held it
  logic [31:0] mi_e = '0, mi_m = '0, mi_w = '0;
  bit          mv_e = 0, mv_m = 0, mv_w = 0;
  int          age_e = 0;

  always @(posedge clk) begin
    if (rst || fw)  mv_w = 0;
    else if (sw)    begin end
    else if (sm)    mv_w = 0;
    else begin mv_w = mv_m; mi_w = mi_m; end

    if (rst || fm)  mv_m = 0;
    else if (sm)    begin end
    else if (se)    mv_m = 0;
    else begin mv_m = mv_e; mi_m = mi_e; end

    if (rst || fe)  begin mv_e = 0; age_e = 0; end
    else if (se)    age_e = age_e + 1;
    else if (sd)    begin mv_e = 0; age_e = 0; end
    else begin mv_e = vld; mi_e = instr; age_e = 0; end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  logic [4:0] act_d_a, act_d_b, act_w_a, act_w_b;
  logic [9:0] act_e_a, act_e_b, act_m_a, act_m_b;
  assign act_d_a = {ifa.branchD, ifa.jumpD, ifa.jrD, ifa.linkD, ifa.reservedD};
  assign act_d_b = {ifb.branchD, ifb.jumpD, ifb.jrD, ifb.linkD, ifb.reservedD};
  assign act_e_a = {ifa.regwriteE, ifa.alusrcAE, ifa.alusrcBE, ifa.immZextE, ifa.memtoRegE,
                    ifa.linkE, ifa.muldivStartE, ifa.validE, ifa.regdstE};
  assign act_e_b = {ifb.regwriteE, ifb.alusrcAE, ifb.alusrcBE, ifb.immZextE, ifb.memtoRegE,
                    ifb.linkE, ifb.muldivStartE, ifb.validE, ifb.regdstE};
  assign act_m_a = {ifa.regwriteM, ifa.memtoRegM, ifa.memWriteM, ifa.memReadM, ifa.memUnsignedM,
                    ifa.validM, ifa.memSizeM, ifa.hiloWeM};
  assign act_m_b = {ifb.regwriteM, ifb.memtoRegM, ifb.memWriteM, ifb.memReadM, ifb.memUnsignedM,
                    ifb.validM, ifb.memSizeM, ifb.hiloWeM};
  assign act_w_a = {ifa.regwriteW, ifa.memtoRegW, ifa.validW, ifa.hiloToRegW};
  assign act_w_b = {ifb.regwriteW, ifb.memtoRegW, ifb.validW, ifb.hiloToRegW};

  // Every cycle: both instances against the model
  always @(negedge clk) begin
    exp_t xe, xm, xw;
    for (int c = 0; c < 2; c++) begin
      bit full = (c == 0);
      xe = mv_e ? dec_model(mi_e, 1, full, full) : '0;
      xm = mv_m ? dec_model(mi_m, 1, full, full) : '0;
      xw = mv_w ? dec_model(mi_w, 1, full, full) : '0;
      if (full) begin
        chk("model_D_full", act_d_a, vd(dec_model(instr, vld, 1, 1)));
        chk("model_E_full", act_e_a, ve(xe, mv_e, mv_e && xe.muldiv && age_e == 0));
        chk("model_M_full", act_m_a, vm(xm, mv_m));
        chk("model_W_full", act_w_a, vw(xw, mv_w));
      end else begin
        chk("model_D_min", act_d_b, vd(dec_model(instr, vld, 0, 0)));
        chk("model_E_min", act_e_b, ve(xe, mv_e, mv_e && xe.muldiv && age_e == 0));
        chk("model_M_min", act_m_b, vm(xm, mv_m));
        chk("model_W_min", act_w_b, vw(xw, mv_w));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    sd = 0; se = 0; sm = 0; sw = 0; fe = 0; fm = 0; fw = 0;
  endtask

  function automatic logic [31:0] rtype(logic [5:0] fn);
    return {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, fn};
  endfunction
  function automatic logic [31:0] itype(logic [5:0] op);
    return {op, 5'd4, 5'd5, 16'h0010};
  endfunction

  logic [5:0] known_ops [16] = '{6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h0c,
                                 6'h0f, 6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h2b};

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int          k;
    logic [4:0]  rt;
    r = $urandom;
    case ($urandom_range(0, 3))
      0: return {6'h00, r[25:6], 6'($urandom_range(0, 47))};
      1: begin
        k = $urandom_range(0, 4);
        rt = (k == 0) ? 5'd0 : (k == 1) ? 5'd1 : (k == 2) ? 5'd16 : (k == 3) ? 5'd17 : r[20:16];
        return {6'h01, r[25:21], rt, r[15:0]};
      end
      2: return r;
      default: return {known_ops[$urandom_range(0, 15)], r[25:0]};
    endcase
  endfunction

  int pulses;

  initial begin
    rst = 1; instr = '0; vld = 0; quiet();
    tick(); tick();
    chk("reset_E", act_e_a, 0);
    chk("reset_M", act_m_a, 0);
    chk("reset_W", act_w_a, 0);
    rst = 0;

    // addu flowing through
    instr = rtype(6'h21); vld = 1;
    tick();
    chk("addu_regwriteE", ifa.regwriteE, 1);
    chk("addu_regdstE", ifa.regdstE, 1);
    chk("addu_memtoRegE", ifa.memtoRegE, 0);
    vld = 0; instr = '0;
    tick();
    chk("addu_regwriteM", ifa.regwriteM, 1);
    chk("addu_memtoRegM", ifa.memtoRegM, 0);
    tick();
    chk("addu_regwriteW", ifa.regwriteW, 1);
    chk("addu_memtoRegW", ifa.memtoRegW, 0);

    // lw then sw back to back
    instr = itype(6'h23); vld = 1;
    tick();
    instr = itype(6'h2b);
    tick();
    chk("lw_memReadM", ifa.memReadM, 1);
    chk("lw_memSizeM", ifa.memSizeM, 2);
    vld = 0;
    tick();
    chk("sw_memWriteM", ifa.memWriteM, 1);
    chk("lw_memtoRegW", ifa.memtoRegW, 1);

    // jal, with and without link support
    instr = {6'h03, 26'h0000040}; vld = 1;
    #1;
    chk("jal_jumpD", ifa.jumpD, 1);
    chk("jal_linkD", ifa.linkD, 1);
    chk("jal_nolink_reservedD", ifb.reservedD, 1);
    chk("jal_nolink_jumpD", ifb.jumpD, 0);
    tick();
    chk("jal_regdstE", ifa.regdstE, 2);
    chk("jal_regwriteE", ifa.regwriteE, 1);
    chk("jal_nolink_regwriteE", ifb.regwriteE, 0);

    // mult held in E for three cycles, mfhi waiting in D
    instr = rtype(6'h18); vld = 1;
    tick();
    pulses = int'(ifa.muldivStartE);
    chk("mult_start_first", ifa.muldivStartE, 1);
    chk("mult_nomd_start", ifb.muldivStartE, 0);
    instr = rtype(6'h10); se = 1; sd = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      pulses += int'(ifa.muldivStartE);
      chk("mult_held_bubbleM", ifa.validM, 0);
    end
    se = 0; sd = 0;
    tick();
    pulses += int'(ifa.muldivStartE);
    chk("mult_hiloWeM", ifa.hiloWeM, 2'b11);
    chk("mult_pulse_count", pulses, 1);
    vld = 0;
    tick(); tick();
    chk("mfhi_hiloToRegW", ifa.hiloToRegW, 2'b10);

    // E held with M free: M fills with bubbles
    instr = rtype(6'h21); vld = 1;
    tick();
    se = 1; sd = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("stallE_validM", ifa.validM, 0);
      chk("stallE_regwriteM", ifa.regwriteM, 0);
      chk("stallE_holdE", ifa.regwriteE, 1);
    end
    quiet();

    // flush beats stall
    instr = itype(6'h23); vld = 1; fe = 1; se = 1; sd = 1;
    tick();
    chk("flush_validE", ifa.validE, 0);
    chk("flush_memtoRegE", ifa.memtoRegE, 0);
    quiet();

    // reset mid-stream
    instr = rtype(6'h21); tick();
    instr = itype(6'h23); tick();
    instr = itype(6'h2b); tick();
    instr = itype(6'h04); rst = 1;
    tick();
    chk("midrst_E", act_e_a, 0);
    chk("midrst_M", act_m_a, 0);
    chk("midrst_W", act_w_a, 0);
    chk("midrst_branchD", ifa.branchD, 1);
    rst = 0;

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      instr = rand_instr();
      vld = ($urandom_range(0, 9) != 0);
      sd  = ($urandom_range(0, 6) == 0);
      se  = ($urandom_range(0, 5) == 0);
      sm  = ($urandom_range(0, 7) == 0);
      sw  = ($urandom_range(0, 9) == 0);
      fe  = ($urandom_range(0, 19) == 0);
      fm  = ($urandom_range(0, 24) == 0);
      fw  = ($urandom_range(0, 29) == 0);
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end

    quiet(); rst = 0; vld = 0;
    tick();
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe_dec.md
Name: ctrl_pipe_dec

Overview:
Parametrised successor to the main control decoder. It decodes the D-stage MIPS instruction into a control bundle and carries that bundle through the E, M and W pipeline registers. Each stage has its own stall and flush, bubbles are inserted when a stage is held, and the mult/div start is a one-shot pulse. It sits beside the datapath; the hazard unit drives the stall/flush inputs.

Parameters:
SUPPORT_MULDIV, 1, 1: decode mult/multu/div/divu/mfhi/mflo/mthi/mtlo; 0: these decode as reserved.
SUPPORT_LINK, 1, 1: decode jal/jalr/bgezal/bltzal with link write; 0: these decode as reserved.
RESET_BUNDLE, 0, value loaded into every stage register on rst/flush (all-zero = bubble).

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
instrD  in  32  D-stage instruction
validD  in  1  instrD holds a real instruction
stallD, stallE, stallM, stallW  in  1 each  hold the stage register
flushE, flushM, flushW  in  1 each  bubble the stage register
branchD, jumpD, jrD, linkD, reservedD  out  1 each  D-stage decode (combinational)
regwriteE, alusrcAE, alusrcBE, immZextE, memtoRegE, linkE, muldivStartE, validE  out  1 each
regdstE  out  2  0=rt, 1=rd, 2=r31
regwriteM, memtoRegM, memWriteM, memReadM, memUnsignedM, validM  out  1 each
memSizeM  out  2  0=byte, 1=half, 2=word
hiloWeM  out  2  bit1=hi, bit0=lo
regwriteW, memtoRegW, validW  out  1 each
hiloToRegW  out  2  01=mflo, 10=mfhi

Behaviour:
- Decode is combinational from instrD.
  - op = [31:26], funct = [5:0], rt = [20:16].
  - validD=0 forces an all-zero bundle.
- Decode covers:
  - R-type ALU and shift ops; alusrcA=1 for sll/srl/sra only.
  - I-type ALU ops; immZext=1 for andi/ori/xori.
  - Loads and stores lb/lbu/lh/lhu/lw/sb/sh/sw, with memSize and memUnsigned set per instruction.
  - beq/bne/bgtz/blez and REGIMM bgez/bltz/bgezal/bltzal.
  - j/jal/jr/jalr and the HI/LO ops.
- Unrecognised op/funct/rt gives reservedD=1 and an otherwise zero bundle. regwrite is never asserted for reserved instructions.
- Link instructions (jal, bgezal, bltzal, jalr): regwrite=1, link=1.
  - jal, bgezal, bltzal: regdst=2.
  - jalr: regdst=1.
- Stage register rule, S in {E, M, W}, P = previous stage, evaluated at each posedge in this priority:
  1. rst or flushS: register <= RESET_BUNDLE, validS <= 0.
  2. stallS: hold.
  3. stallP (P still holding its instruction): register <= bubble, validS <= 0.
  4. Otherwise: register <= P's bundle and valid.
- Flush beats stall in the same cycle. Latency D->E->M->W is one cycle per stage with no stalls.
- mult/div one-shot:
  - Internal flag issuedE is set when muldivStartE=1 and stallE=1.
  - issuedE clears whenever E loads, flushes or resets.
  - muldivStartE = muldivE & ~issuedE, so the pulse lasts exactly one cycle per instruction regardless of how long E is stalled.
- rst mid-operation: all stage registers and issuedE clear on the next edge; D-stage outputs still follow instrD.
- All E/M/W outputs are 0 after reset.

Test Plan:
- addu (op 0x00, funct 0x21), no stalls: regwriteE=1 and regdstE=1 at cycle 1; regwriteM=1 at cycle 2; regwriteW=1 at cycle 3; memtoReg=0 throughout.
- lw (op 0x23) then sw (op 0x2B) back to back: memReadM=1, memSizeM=2 at cycle 2; memWriteM=1 at cycle 3; memtoRegW=1 at cycle 3.
- jal (op 0x03): jumpD=1, linkD=1; then regdstE=2, regwriteE=1. Repeat with SUPPORT_LINK=0: reservedD=1, regwriteE=0.
- mult (funct 0x18) with stallE held 3 cycles: muldivStartE high for exactly 1 cycle; hiloWeM=11 once E releases; mfhi (funct 0x10) later gives hiloToRegW=10.
- stallE=1, stallM=0 for 2 cycles: M receives 2 bubbles (validM=0, regwriteM=0) while E holds its bundle.
- flushE and stallE asserted together with a lw in D: E becomes a bubble. rst asserted mid-stream: all E/M/W outputs are 0 on the next edge.
